// File: rtl/fa_ctrl_fsm.sv
// fa_ctrl_fsm: control FSM for the factorial accelerator.
// Loads R0=n, R1=1 and R2=1 into the datapath register file, then loops:
//   CHECK (R0==0?) -> MUL (R1*=R0) -> DEC (R0-=R2)
// until R0 reaches zero. The factorial is left in R1.
// Optional build macro FA_WATCHDOG_EN adds a busy-cycle watchdog that forces
// DONE with err set after TIMEOUT_CYCLES busy cycles.
module fa_ctrl_fsm #(
  parameter int N_WIDTH        = 5,
  parameter int MAX_N          = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N_WIDTH-1:0] n,
  input  logic               is_zero,
  output logic [1:0]         read_add1,
  output logic [1:0]         read_add2,
  output logic [1:0]         write_add,
  output logic               wd_selec,
  output logic               write_en,
  output logic [2:0]         operation,
  output logic [31:0]        write_data,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_N, S_LOAD_ACC, S_LOAD_ONE, S_CHECK, S_MUL, S_DEC, S_DONE
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;

  localparam logic [N_WIDTH-1:0] MAX_N_W = N_WIDTH'(MAX_N);

  // The watchdog counter is 8 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  state_t             state_q, state_d;
  logic [N_WIDTH-1:0] n_q, n_d;
  logic               err_q, err_d;
  logic               accept;

  assign err = err_q;

`ifdef FA_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wd_q, wd_d;
`endif

  // State and operand registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      err_q   <= 1'b0;
`ifdef FA_WATCHDOG_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      err_q   <= err_d;
`ifdef FA_WATCHDOG_EN
      wd_q    <= wd_d;
`endif
    end
  end

  // Next-state logic and Moore decode of the datapath controls.
  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    err_d      = err_q;
    accept     = 1'b0;
    read_add1  = 2'd0;
    read_add2  = 2'd0;
    write_add  = 2'd0;
    wd_selec   = 1'b0;
    write_en   = 1'b0;
    operation  = OP_ADD;
    write_data = 32'd0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (n <= MAX_N_W) begin
            accept  = 1'b1;
            n_d     = n;
            err_d   = 1'b0;
            state_d = S_LOAD_N;
          end else begin
            // Out-of-range request: report immediately, touch nothing.
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_LOAD_N: begin
        busy       = 1'b1;
        write_add  = 2'd0;
        wd_selec   = 1'b1;
        write_data = {{(32-N_WIDTH){1'b0}}, n_q};
        write_en   = 1'b1;
        state_d    = S_LOAD_ACC;
      end
      S_LOAD_ACC: begin
        busy       = 1'b1;
        write_add  = 2'd1;
        wd_selec   = 1'b1;
        write_data = 32'd1;
        write_en   = 1'b1;
        state_d    = S_LOAD_ONE;
      end
      S_LOAD_ONE: begin
        busy       = 1'b1;
        write_add  = 2'd2;
        wd_selec   = 1'b1;
        write_data = 32'd1;
        write_en   = 1'b1;
        state_d    = S_CHECK;
      end
      S_CHECK: begin
        busy      = 1'b1;
        read_add1 = 2'd0;
        operation = OP_PASS;
        state_d   = is_zero ? S_DONE : S_MUL;
      end
      S_MUL: begin
        busy      = 1'b1;
        read_add1 = 2'd1;
        read_add2 = 2'd0;
        operation = OP_MUL;
        write_add = 2'd1;
        write_en  = 1'b1;
        state_d   = S_DEC;
      end
      S_DEC: begin
        busy      = 1'b1;
        read_add1 = 2'd0;
        read_add2 = 2'd2;
        operation = OP_SUB;
        write_add = 2'd0;
        write_en  = 1'b1;
        state_d   = S_CHECK;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef FA_WATCHDOG_EN
    // Count busy cycles; on the last allowed one, abandon the run. This
    // cycle's write (Moore-decoded above) still happens.
    wd_d = wd_q;
    if (accept) begin
      wd_d = '0;
    end else if (busy) begin
      wd_d = wd_q + 8'd1;
      if (wd_q == WD_LAST) begin
        state_d = S_DONE;
        err_d   = 1'b1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_fa_ctrl_fsm.sv
// Bench for fa_ctrl_fsm: behavioural General datapath around the DUT, a
// driver that pushes expected outcomes (n!, done cycle, err, write count)
// into a queue, and a monitor that pops and compares on every done pulse.
module tb_fa_ctrl_fsm;
  localparam int NW = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [NW-1:0] n = '0;
  logic          is_zero;
  logic [1:0]    read_add1, read_add2, write_add;
  logic          wd_selec, write_en, busy, done, err;
  logic [2:0]    operation;
  logic [31:0]   write_data;

  fa_ctrl_fsm dut (
    .clk(clk), .reset(reset), .start(start), .n(n), .is_zero(is_zero),
    .read_add1(read_add1), .read_add2(read_add2), .write_add(write_add),
    .wd_selec(wd_selec), .write_en(write_en), .operation(operation),
    .write_data(write_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural datapath: 4x32 register file plus ALU.
  logic [31:0] rf [4] = '{default: 32'd0};
  logic [31:0] alu_a, alu_b, alu_y;
  always_comb begin
    alu_a = rf[read_add1];
    alu_b = rf[read_add2];
    case (operation)
      3'd0:    alu_y = alu_a + alu_b;
      3'd1:    alu_y = alu_a - alu_b;
      3'd2:    alu_y = alu_a * alu_b;
      default: alu_y = alu_a;
    endcase
  end
  assign is_zero = (alu_y == 32'd0);
  always @(posedge clk) if (write_en) rf[write_add] <= wd_selec ? write_data : alu_y;

  // Reference model and scoreboard
  typedef struct {
    int          acc;     // cyc value in the cycle start was presented
    int          due;     // cyc value in which done must be high
    bit          err;
    int          writes;
    logic [31:0] res;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int fails  = 0;
  int wcount = 0;

  function automatic logic [31:0] fact(input int k);
    logic [31:0] p = 32'd1;
    for (int i = 2; i <= k; i++) p = p * 32'(i);
    return p;
  endfunction

  function automatic exp_t model(input int nv, input int acc);
    exp_t e;
    e.acc = acc;
    if (nv > 12) begin
      e.err = 1'b1; e.due = acc + 1; e.writes = 0; e.res = 32'd0;
    end else begin
      e.err = 1'b0; e.due = acc + 3 * nv + 5; e.writes = 3 + 2 * nv; e.res = fact(nv);
    end
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, expv);
    end
  endtask

  // Monitor: per-cycle busy/done checks and scoreboard pop on done.
  always @(negedge clk) begin
    if (!reset) begin
      wcount = 0;
    end else begin
      if (write_en) wcount++;
      if (operation > 3'd3) chk("reserved_opcode", operation, 0);
      if (q.size() > 0 && cyc > q[0].acc && cyc < q[0].due)
        chk("busy_during_run", {busy, done}, 2);
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("done_err", err, e.err);
          chk("done_busy", busy, 0);
          chk("write_count", wcount, e.writes);
          if (!e.err) begin
            chk("result_R1", rf[1], e.res);
            chk("final_R0", rf[0], 0);
            chk("const_R2", rf[2], 1);
          end
        end
        wcount = 0;
      end else if (q.size() > 0 && cyc > q[0].due) begin
        chk("missing_done", cyc, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  // Present one request for one cycle; caller guarantees the DUT is idle.
  task automatic issue(input int nv);
    start = 1'b1;
    n = NW'(nv);
    q.push_back(model(nv, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Bounded wait for the scoreboard to drain, then land in an idle cycle.
  task automatic wait_idle();
    int i;
    for (i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset for two cycles, then release.
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_we", write_en, 0);
    chk("rst_err", err, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_op", operation, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 7) chk("idle_hold", {busy, done, write_en}, 0);
    end

    // Directed runs.
    issue(5);  wait_idle();
    issue(0);  wait_idle();
    issue(12); wait_idle();
    issue(13); wait_idle();
    chk("err_holds", err, 1);
    issue(1);  wait_idle();
    chk("err_cleared", err, 0);

    // start held through an n=3 run: exactly one re-acceptance after IDLE.
    begin
      exp_t e1, e2;
      e1 = model(3, cyc);
      e2 = model(3, e1.due + 1);
      start = 1'b1; n = NW'(3);
      q.push_back(e1); q.push_back(e2);
      repeat (e1.due - e1.acc + 2) @(negedge clk);
      start = 1'b0;
      wait_idle();
    end

    // Reset during MUL of an n=6 run aborts with no done and no writes.
    begin
      start = 1'b1; n = NW'(6);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("in_mul_op", operation, 2);
      chk("in_mul_we", write_en, 1);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_we", write_en, 0);
      chk("abort_done", done, 0);
      for (int i = 0; i < 25; i++) begin
        @(negedge clk);
        if (write_en || done) chk("abort_quiet", {write_en, done}, 0);
      end
      chk("abort_idle", busy, 0);
    end

    // Randomized requests with random idle gaps, including out-of-range n.
    for (int k = 0; k < 16; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(int'($urandom_range(0, 16)));
      wait_idle();
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout at cyc %0d: got running expected finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fa_ctrl_fsm.md
Name: fa_ctrl_fsm

Overview:
- Control unit for the factorial accelerator.
- Sequences the General datapath (2-read/1-write register file plus ALU) to compute n! for an n supplied with a start pulse.
- Drives the datapath's read_add1, read_add2, write_add, wd_selec, write_en, operation and write_data, and consumes its is_zero flag.
- Sits directly upstream of General inside FA_Main; the factorial is read from datapath register R1 (the `result` bus).

Parameters:
- N_WIDTH, 5, width of operand n.
- MAX_N, 12, largest n accepted (12! is the largest factorial that fits in 32 bits).
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with FA_WATCHDOG_EN.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clk.
- start  in  1  request pulse; sampled only in IDLE.
- n  in  N_WIDTH  operand; captured when start is accepted.
- is_zero  in  1  combinational datapath flag: the current ALU result equals 0.
- read_add1  out  2  register-file read address A.
- read_add2  out  2  register-file read address B.
- write_add  out  2  register-file write address.
- wd_selec  out  1  write-data select: 0 = ALU result, 1 = write_data immediate.
- write_en  out  1  register-file write enable.
- operation  out  3  ALU opcode: 000 ADD, 001 SUB, 010 MUL, 011 PASS_A; all others reserved, never driven.
- write_data  out  32  immediate value written when wd_selec=1.
- busy  out  1  computation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  last request rejected or aborted.

Behaviour:
- Register map: R0 = down-counter, R1 = accumulator/result, R2 = constant 1; R3 unused.
- Outputs are Moore-decoded from the registered state. n_q and err are registers.
- Reset (reset=0 at an edge): state goes to IDLE, err=0, n_q=0.
  - IDLE decode: all address outputs 0, wd_selec=0, write_en=0, operation=000, write_data=0, busy=0, done=0.
  - Reset mid-operation aborts immediately and issues no further writes. Datapath register contents are not touched by this block.
- IDLE:
  - start=1 with n<=MAX_N: capture n_q=n, clear err, go to LOAD_N.
  - start=1 with n>MAX_N: go to DONE with err set; no register writes occur.
  - start=0: stay in IDLE.
- LOAD_N: write_add=0, wd_selec=1, write_data=zero-extended n_q, write_en=1. Go to LOAD_ACC.
- LOAD_ACC: write_add=1, wd_selec=1, write_data=1, write_en=1. Go to LOAD_ONE.
- LOAD_ONE: write_add=2, wd_selec=1, write_data=1, write_en=1. Go to CHECK.
- CHECK: read_add1=0, operation=PASS_A, write_en=0.
  - is_zero=1: go to DONE.
  - is_zero=0: go to MUL.
- MUL: read_add1=1, read_add2=0, operation=MUL, write_add=1, wd_selec=0, write_en=1. Go to DEC.
- DEC: read_add1=0, read_add2=2, operation=SUB, write_add=0, wd_selec=0, write_en=1. Go to CHECK.
- DONE: done=1 for exactly one cycle, write_en=0. Go to IDLE.
- busy=1 in every state except IDLE and DONE.
- start is ignored whenever state is not IDLE, including while in DONE.
- Latency: done is high in the cycle 3n+5 clocks after the edge that accepts start.
  - n=0 gives 5 cycles, R1=1 (0! = 1).
  - n>MAX_N gives 1 cycle, with err=1.
- err holds until the next accepted start or reset.
- The MUL result is truncated to 32 bits by the datapath. MAX_N guarantees no overflow.

Optional Feature:
- Macro: FA_WATCHDOG_EN.
- Defined:
  - An 8-bit cycle counter clears on start acceptance and increments every busy cycle.
  - If the counter reaches TIMEOUT_CYCLES while busy, force state to DONE with err=1; the current cycle's write_en is still honoured, and no writes follow.
  - This covers a stuck or faulty is_zero.
- Not defined: no counter logic; a stuck is_zero=0 loops indefinitely.

Test Plan:
- reset=0 for 2 cycles, then release -> busy=0, done=0, write_en=0, err=0; start=0 keeps IDLE indefinitely.
- start with n=5 (real General datapath) -> done pulse 20 cycles after acceptance; result=120; err=0; busy high for cycles 1..19.
- start with n=0 -> done 5 cycles later; result=1; exactly three writes: R0=0, R1=1, R2=1.
- start with n=12 -> result=479001600, done at cycle 41; then start with n=13 -> done next cycle, err=1, zero write_en pulses.
- start held high throughout an n=3 run -> only one computation; the second request is accepted only after returning to IDLE.
- Assert reset=0 during MUL of an n=6 run -> next cycle is IDLE, write_en=0, no done pulse. FA_WATCHDOG_EN with is_zero stuck 0 -> done with err=1 after 64 busy cycles.
